// File: rtl/nvram_arbiter.sv
// nvram_arbiter: shares CMOS RAM between the CPU and HPS ioctl save/load, halting the CPU during transfers
module nvram_arbiter #(
  parameter int          AW          = 10,
  parameter logic [15:0] NV_INDEX    = 16'd4,
  parameter int          ACK_TIMEOUT = 255
) (
  input  logic          clk_sys,
  input  logic          reset,
  input  logic          ioctl_download,
  input  logic          ioctl_upload,
  input  logic [15:0]   ioctl_index,
  input  logic [24:0]   ioctl_addr,
  input  logic [7:0]    ioctl_dout,
  input  logic          ioctl_wr,
  input  logic          ioctl_rd,
  output logic [7:0]    ioctl_din,
  output logic          ioctl_wait,
  output logic          cpu_hold,
  input  logic          cpu_hold_ack,
  input  logic [AW-1:0] cpu_addr,
  input  logic          cpu_we,
  input  logic [7:0]    cpu_din,
  output logic [7:0]    cpu_dout,
  output logic [AW-1:0] ram_addr,
  output logic          ram_we,
  output logic [7:0]    ram_din,
  input  logic [7:0]    ram_dout,
  output logic          nvram_dirty
);
  typedef enum logic [2:0] {IDLE, HOLD, DL, UL_IDLE, UL_DATA, RELEASE} state_t;
  localparam int CW = $clog2(ACK_TIMEOUT + 1);
  state_t state, state_nx;
  logic [CW-1:0] cnt;
  logic [7:0] cpu_dout_q;
  logic sel, sel_q, sel_rise, go, in_range, in_range_q;
  assign sel      = (ioctl_download | ioctl_upload) && ioctl_index == NV_INDEX;
  assign sel_rise = sel & ~sel_q;
  assign go       = cpu_hold_ack || cnt == CW'(ACK_TIMEOUT);
  assign in_range = ioctl_addr[24:AW] == '0;
  // sel_q tracks sel through reset so an aborted transfer is not restarted
  always_ff @(posedge clk_sys) begin
    sel_q <= sel;
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      nvram_dirty <= 1'b0;
      ioctl_din   <= 8'hFF;
      in_range_q  <= 1'b0;
      cpu_dout_q  <= '0;
    end else begin
      state       <= state_nx;
      cnt         <= state != HOLD ? '0 : cnt == CW'(ACK_TIMEOUT) ? cnt : cnt + 1'b1;
      nvram_dirty <= (cpu_we && (state == IDLE || state == RELEASE)) || (nvram_dirty && state != RELEASE);
      if (state == UL_IDLE && ioctl_rd) in_range_q <= in_range;
      if (state == UL_DATA) ioctl_din <= in_range_q ? ram_dout : 8'hFF;
      if (state == IDLE) cpu_dout_q <= ram_dout;
    end
  end
  always_comb begin
    state_nx   = state;
    cpu_hold   = 1'b0;
    ioctl_wait = 1'b0;
    ram_addr   = cpu_addr;
    ram_we     = 1'b0;
    ram_din    = cpu_din;
    cpu_dout   = cpu_dout_q;
    case (state)
      IDLE: begin
        ram_we     = cpu_we;
        cpu_dout   = ram_dout;
        ioctl_wait = sel_rise;
        if (sel_rise) state_nx = HOLD;
      end
      HOLD: begin
        cpu_hold   = 1'b1;
        ioctl_wait = ~go;
        if (!sel) state_nx = RELEASE;
        else if (go) state_nx = ioctl_download ? DL : UL_IDLE;
      end
      DL: begin
        cpu_hold = 1'b1;
        ram_addr = ioctl_addr[AW-1:0];
        ram_din  = ioctl_dout;
        ram_we   = ioctl_wr & in_range;
        if (!sel) state_nx = RELEASE;
      end
      UL_IDLE: begin
        cpu_hold = 1'b1;
        ram_addr = ioctl_addr[AW-1:0];
        if (!sel) state_nx = RELEASE;
        else if (ioctl_rd) begin
          ioctl_wait = 1'b1;
          state_nx   = UL_DATA;
        end
      end
      UL_DATA: begin
        cpu_hold = 1'b1;
        ram_addr = ioctl_addr[AW-1:0];
        state_nx = UL_IDLE;
      end
      RELEASE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end
endmodule

// File: tb/tb_nvram_arbiter.sv
// tb_nvram_arbiter: directed scenario tests for nvram_arbiter against a behavioural 1K x 8 sync RAM
module tb_nvram_arbiter;
  logic clk_sys = 1'b0, reset = 1'b1;
  logic ioctl_download = 0, ioctl_upload = 0, ioctl_wr = 0, ioctl_rd = 0;
  logic [15:0] ioctl_index = '0;
  logic [24:0] ioctl_addr = '0;
  logic [7:0] ioctl_dout = '0, ioctl_din, cpu_din = '0, cpu_dout, ram_din, ram_dout;
  logic ioctl_wait, cpu_hold, cpu_hold_ack = 0, cpu_we = 0, ram_we, nvram_dirty;
  logic [9:0] cpu_addr = '0, ram_addr;
  logic [7:0] mem [0:1023];
  int checks = 0, fails = 0;

  nvram_arbiter dut (
    .clk_sys(clk_sys), .reset(reset),
    .ioctl_download(ioctl_download), .ioctl_upload(ioctl_upload), .ioctl_index(ioctl_index),
    .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout), .ioctl_wr(ioctl_wr), .ioctl_rd(ioctl_rd),
    .ioctl_din(ioctl_din), .ioctl_wait(ioctl_wait), .cpu_hold(cpu_hold), .cpu_hold_ack(cpu_hold_ack),
    .cpu_addr(cpu_addr), .cpu_we(cpu_we), .cpu_din(cpu_din), .cpu_dout(cpu_dout),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_din(ram_din), .ram_dout(ram_dout),
    .nvram_dirty(nvram_dirty)
  );

  always #5 clk_sys = ~clk_sys;

  always @(posedge clk_sys) begin
    if (ram_we) mem[ram_addr] <= ram_din;
    ram_dout <= mem[ram_addr];
  end

  task automatic tick;
    @(posedge clk_sys);
    #1;
  endtask

  task automatic dl_byte(input int a, input logic [7:0] d);
    ioctl_addr = 25'(a);
    ioctl_dout = d;
    ioctl_wr = 1;
    tick;
    ioctl_wr = 0;
    repeat (3) tick;
  endtask

  task automatic test_reset;
    reset = 1;
    repeat (3) tick;
    checks++; if (cpu_hold !== 1'b0) begin fails++; $display("FAIL reset_cpu_hold: got %b want 0", cpu_hold); end
    checks++; if (ioctl_wait !== 1'b0) begin fails++; $display("FAIL reset_ioctl_wait: got %b want 0", ioctl_wait); end
    checks++; if (ioctl_din !== 8'hFF) begin fails++; $display("FAIL reset_ioctl_din: got %h want ff", ioctl_din); end
    checks++; if (ram_we !== 1'b0) begin fails++; $display("FAIL reset_ram_we: got %b want 0", ram_we); end
    checks++; if (nvram_dirty !== 1'b0) begin fails++; $display("FAIL reset_dirty: got %b want 0", nvram_dirty); end
    reset = 0;
    tick;
  endtask

  task automatic test_passthrough;
    cpu_addr = 10'h010; cpu_din = 8'h5A; cpu_we = 1;
    #1;
    checks++; if (ram_we !== 1'b1 || ram_addr !== 10'h010) begin fails++; $display("FAIL pass_write: got we=%b addr=%h want we=1 addr=010", ram_we, ram_addr); end
    tick;
    cpu_we = 0;
    tick;
    checks++; if (cpu_dout !== 8'h5A) begin fails++; $display("FAIL pass_read: got %h want 5a", cpu_dout); end
    checks++; if (nvram_dirty !== 1'b1) begin fails++; $display("FAIL pass_dirty: got %b want 1", nvram_dirty); end
  endtask

  task automatic test_download;
    int err = 0;
    ioctl_index = 16'd4; ioctl_download = 1; cpu_hold_ack = 0;
    #1;
    checks++; if (ioctl_wait !== 1'b1 || cpu_hold !== 1'b0) begin fails++; $display("FAIL dl_start: got wait=%b hold=%b want wait=1 hold=0", ioctl_wait, cpu_hold); end
    repeat (4) begin
      tick;
      if (ioctl_wait !== 1'b1 || cpu_hold !== 1'b1) err++;
    end
    checks++; if (err != 0) begin fails++; $display("FAIL dl_hold_wait: got %0d bad cycles want 0", err); end
    tick;
    cpu_hold_ack = 1;
    #1;
    checks++; if (ioctl_wait !== 1'b0 || cpu_hold !== 1'b1) begin fails++; $display("FAIL dl_ack: got wait=%b hold=%b want wait=0 hold=1", ioctl_wait, cpu_hold); end
    tick;
    for (int a = 0; a < 1024; a++) dl_byte(a, 8'(a ^ 8'h3C));
    checks++; if (cpu_hold !== 1'b1) begin fails++; $display("FAIL dl_hold_during: got %b want 1", cpu_hold); end
    ioctl_addr = 25'd1024; ioctl_dout = 8'h77; ioctl_wr = 1;
    #1;
    checks++; if (ram_we !== 1'b0) begin fails++; $display("FAIL dl_oor_discard: got ram_we=%b want 0", ram_we); end
    tick;
    ioctl_wr = 0;
    tick;
    ioctl_download = 0;
    tick;
    checks++; if (cpu_hold !== 1'b0) begin fails++; $display("FAIL dl_release: got hold=%b want 0", cpu_hold); end
    tick;
    cpu_hold_ack = 0;
    #1;
    checks++; if (nvram_dirty !== 1'b0) begin fails++; $display("FAIL dl_dirty_clear: got %b want 0", nvram_dirty); end
    err = 0;
    for (int a = 0; a < 1024; a++) if (mem[a] !== 8'(a ^ 8'h3C)) err++;
    checks++; if (err != 0) begin fails++; $display("FAIL dl_ram_contents: got %0d wrong bytes want 0", err); end
  endtask

  task automatic test_upload;
    int addrs [3] = '{1023, 5, 1024};
    logic [7:0] exp [3] = '{8'hA7, 8'h39, 8'hFF};
    cpu_addr = 10'h3FF; cpu_din = 8'hA7; cpu_we = 1;
    tick;
    cpu_we = 0;
    ioctl_index = 16'd4; ioctl_upload = 1; cpu_hold_ack = 1;
    #1;
    checks++; if (nvram_dirty !== 1'b1) begin fails++; $display("FAIL ul_dirty_set: got %b want 1", nvram_dirty); end
    tick;
    tick;
    for (int i = 0; i < 3; i++) begin
      ioctl_addr = 25'(addrs[i]); ioctl_rd = 1;
      #1;
      checks++; if (ioctl_wait !== 1'b1) begin fails++; $display("FAIL ul_wait_%0d: got %b want 1", i, ioctl_wait); end
      tick;
      ioctl_rd = 0;
      tick;
      checks++; if (ioctl_din !== exp[i]) begin fails++; $display("FAIL ul_data_%0d: got %h want %h", i, ioctl_din, exp[i]); end
      tick;
    end
    ioctl_upload = 0;
    tick;
    tick;
    cpu_hold_ack = 0;
    #1;
    checks++; if (nvram_dirty !== 1'b0 || cpu_hold !== 1'b0) begin fails++; $display("FAIL ul_end: got dirty=%b hold=%b want 0 0", nvram_dirty, cpu_hold); end
  endtask

  task automatic test_timeout;
    int n = 0;
    ioctl_index = 16'd4; ioctl_download = 1; cpu_hold_ack = 0;
    #1;
    while (ioctl_wait === 1'b1 && n < 400) begin
      n++;
      if (n == 10) begin
        cpu_addr = 10'h007; cpu_din = 8'hEE; cpu_we = 1;
        #1;
        checks++; if (ram_we !== 1'b0) begin fails++; $display("FAIL to_cpu_drop: got ram_we=%b want 0", ram_we); end
      end
      tick;
      cpu_we = 0;
    end
    checks++; if (n != 256) begin fails++; $display("FAIL to_wait_cycles: got %0d want 256", n); end
    checks++; if (nvram_dirty !== 1'b0) begin fails++; $display("FAIL to_dirty: got %b want 0", nvram_dirty); end
    tick;
    dl_byte(7, 8'h99);
    checks++; if (mem[7] !== 8'h99) begin fails++; $display("FAIL to_forced_write: got %h want 99", mem[7]); end
    ioctl_download = 0;
    repeat (3) tick;
  endtask

  task automatic test_other_index;
    int err = 0;
    ioctl_index = 16'd0; ioctl_download = 1;
    for (int i = 0; i < 8; i++) begin
      ioctl_addr = 25'h10; ioctl_dout = 8'h11; ioctl_wr = (i == 2);
      #1;
      if (cpu_hold !== 1'b0 || ioctl_wait !== 1'b0) err++;
      tick;
    end
    ioctl_wr = 0; ioctl_download = 0;
    tick;
    checks++; if (err != 0) begin fails++; $display("FAIL idx0_no_hold: got %0d bad cycles want 0", err); end
    checks++; if (mem[16] !== 8'h2C) begin fails++; $display("FAIL idx0_ram: got %h want 2c", mem[16]); end
  endtask

  task automatic test_reset_mid;
    int err = 0;
    ioctl_index = 16'd4; ioctl_download = 1; cpu_hold_ack = 1;
    tick;
    tick;
    for (int a = 0; a < 300; a++) dl_byte(a, 8'(a ^ 8'h55));
    reset = 1;
    tick;
    reset = 0;
    #1;
    checks++; if (cpu_hold !== 1'b0 || dut.state !== 3'd0) begin fails++; $display("FAIL rst_mid_abort: got hold=%b state=%0d want 0 0", cpu_hold, dut.state); end
    ioctl_addr = 25'd300; ioctl_dout = 8'hEE; ioctl_wr = 1;
    #1;
    checks++; if (ram_we !== 1'b0) begin fails++; $display("FAIL rst_mid_wr_ignored: got ram_we=%b want 0", ram_we); end
    tick;
    ioctl_wr = 0;
    tick;
    ioctl_download = 0; cpu_hold_ack = 0;
    tick;
    checks++; if (cpu_hold !== 1'b0) begin fails++; $display("FAIL rst_mid_no_restart: got %b want 0", cpu_hold); end
    for (int a = 0; a < 300; a++) if (mem[a] !== 8'(a ^ 8'h55)) err++;
    checks++; if (err != 0) begin fails++; $display("FAIL rst_mid_retained: got %0d wrong bytes want 0", err); end
    checks++; if (mem[300] !== 8'h10) begin fails++; $display("FAIL rst_mid_byte300: got %h want 10", mem[300]); end
  endtask

  task automatic test_release_we;
    ioctl_index = 16'd4; ioctl_download = 1; cpu_hold_ack = 1;
    tick;
    tick;
    ioctl_download = 0;
    tick;
    cpu_addr = 10'h020; cpu_din = 8'h44; cpu_we = 1;
    #1;
    checks++; if (cpu_hold !== 1'b0 || ram_we !== 1'b0) begin fails++; $display("FAIL rel_cycle: got hold=%b we=%b want 0 0", cpu_hold, ram_we); end
    tick;
    cpu_we = 0; cpu_hold_ack = 0;
    #1;
    checks++; if (nvram_dirty !== 1'b1) begin fails++; $display("FAIL rel_dirty_wins: got %b want 1", nvram_dirty); end
    tick;
    checks++; if (mem[32] !== 8'h75) begin fails++; $display("FAIL rel_write_dropped: got %h want 75", mem[32]); end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
    test_reset;
    test_passthrough;
    test_download;
    test_upload;
    test_timeout;
    test_other_index;
    test_reset_mid;
    test_release_we;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule

// File: doc/nvram_arbiter.md
Name: nvram_arbiter

Overview:
Arbitrates the game's battery-backed CMOS RAM between the williams2 CPU and the HPS ioctl save/load path, so high-score tables and settings persist across sessions. It sits between hps_io, the CPU CMOS bus and a single-port synchronous RAM. During an HPS transfer it halts the CPU, waits for acknowledge, then streams bytes in or out. Outside transfers it passes CPU accesses straight through and tracks a dirty flag for autosave.

Parameters:
AW, 10, RAM address width (1K entries)
NV_INDEX, 16'd4, ioctl_index value that selects the NVRAM transfer
ACK_TIMEOUT, 255, clk_sys cycles to wait for cpu_hold_ack before forcing ownership

Ports:
clk_sys  in  1  system clock (12 MHz)
reset  in  1  synchronous, active-high
ioctl_download  in  1  HPS download active
ioctl_upload  in  1  HPS upload active
ioctl_index  in  16  transfer index
ioctl_addr  in  25  byte address
ioctl_dout  in  8  download data
ioctl_wr  in  1  download byte strobe
ioctl_rd  in  1  upload byte request strobe
ioctl_din  out  8  upload data
ioctl_wait  out  1  stall HPS
cpu_hold  out  1  request CPU halt
cpu_hold_ack  in  1  CPU halted
cpu_addr  in  AW  CPU CMOS address
cpu_we  in  1  CPU write strobe (one clk_sys cycle)
cpu_din  in  8  CPU write data
cpu_dout  out  8  CPU read data
ram_addr  out  AW  RAM address
ram_we  out  1  RAM write enable
ram_din  out  8  RAM write data
ram_dout  in  8  RAM read data, 1-cycle latency
nvram_dirty  out  1  CPU has written since last save/load

Behaviour:
- Reset values: state IDLE, cpu_hold=0, ioctl_wait=0, ioctl_din=8'hFF, ram_we=0, nvram_dirty=0. Reset mid-transfer aborts it; CPU released next cycle.
- Transfer "selected" = (ioctl_download|ioctl_upload) && ioctl_index==NV_INDEX. Other indices are ignored entirely.
- States:
 - IDLE: ram_addr=cpu_addr, ram_we=cpu_we, ram_din=cpu_din, cpu_dout=ram_dout (combinational mux). On selected rising edge -> HOLD; cpu_hold=1, ioctl_wait=1, timeout counter cleared.
 - HOLD: cpu_hold=1, ioctl_wait=1. cpu_hold_ack=1 or counter==ACK_TIMEOUT -> DL (download) or UL_IDLE (upload); ioctl_wait drops on the transition cycle. Selected drops while in HOLD -> RELEASE.
 - DL: ioctl_wr with ioctl_addr < 2^AW -> ram_we=1, ram_addr=ioctl_addr[AW-1:0], ram_din=ioctl_dout in the same cycle. Higher addresses are discarded. Download end -> RELEASE.
 - UL_IDLE: ioctl_rd -> ram_addr=ioctl_addr[AW-1:0], ioctl_wait=1, -> UL_DATA.
 - UL_DATA: ioctl_din<=ram_dout (8'hFF if address >= 2^AW), ioctl_wait=0, -> UL_IDLE. Read latency is 2 cycles from ioctl_rd to valid ioctl_din. Upload end -> RELEASE (from UL_IDLE; in UL_DATA the byte completes first).
 - RELEASE: cpu_hold=0 for one cycle, clears nvram_dirty, -> IDLE.
- CPU writes while not in IDLE are dropped (CPU is halted or forced). cpu_dout is held at its last IDLE value outside IDLE.
- nvram_dirty is set by any cpu_we in IDLE. If cpu_we and the RELEASE clear coincide, the set wins.
- The timeout counter saturates and never wraps.
- The ioctl_wr/ioctl_rd strobes are single-cycle and at least 3 cycles apart (hps_io guarantee). No buffering beyond one byte.

Test Plan:
- CPU passthrough: cpu_we addr 0x010 data 0x5A, read back -> cpu_dout=0x5A one cycle after addr is presented; nvram_dirty=1.
- Download index 4, ack after 5 cycles, 1024 bytes pattern addr^0x3C -> ioctl_wait high exactly until ack; RAM holds pattern; cpu_hold drops after the end; nvram_dirty=0.
- Upload index 4 after a CPU write of 0xA7 to 0x3FF -> byte 1023 returns 0xA7 two cycles after ioctl_rd; ioctl_addr 1024 returns 0xFF.
- No ack: cpu_hold_ack stuck 0 -> transfer proceeds after 255 cycles; download index 0 -> no cpu_hold, RAM untouched.
- Reset asserted mid-download at byte 300 -> cpu_hold=0 and state IDLE the next cycle; bytes 0..299 retained.
- cpu_we coincident with the RELEASE cycle -> nvram_dirty ends at 1.
